// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Optional build macro: BOOTH_SIGNED_SEL_EN (adds a signed/unsigned operand select).
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NOP,
      ADD,
      SUB
   } booth_op_t;

   // Number of bits needed to hold values 0..v-1 (at least 0)
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle for booth_mult_seq.
// Optional build macro: BOOTH_SIGNED_SEL_EN (adds is_signed, sampled with the operands).
interface booth_mult_seq_if #(parameter int WIDTH = 8);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     multcand;
   logic [WIDTH-1:0]     multplr;
`ifdef BOOTH_SIGNED_SEL_EN
   logic                 is_signed;
`endif
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;

   modport master (
`ifdef BOOTH_SIGNED_SEL_EN
      output is_signed,
`endif
      output in_valid, multcand, multplr, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
`ifdef BOOTH_SIGNED_SEL_EN
      input  is_signed,
`endif
      input  in_valid, multcand, multplr, out_ready,
      output in_ready, out_valid, product
   );

endinterface

// File: rtl/addsub_param.sv
// Ripple-carry add/subtract: sum = a + (b ^ {W{cin}}) + cin.
// With cin=1 this computes a - b.
module addsub_param #(
   parameter int W = 9
) (
   input  logic         cin,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   logic [W-1:0] b_x;

   assign b_x = b ^ {W{cin}};

   // Bit-serial ripple through the carry chain
   always_comb begin : ripple
      logic carry;
      sum   = '0;
      carry = cin;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b_x[i] ^ carry;
         carry  = (a[i] & b_x[i]) | (carry & (a[i] ^ b_x[i]));
      end
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready on operands and product.
// Optional build macro: BOOTH_SIGNED_SEL_EN (per-operation signed/unsigned select;
// unsigned operations take one extra Booth step).
//
// state | meaning
// IDLE  | ready for an operand pair
// CALC  | one add/sub + arithmetic shift per cycle
// DONE  | product presented, waiting for out_ready
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   booth_mult_seq_if.slave  bus
);

   localparam int AW = WIDTH + 1;
`ifdef BOOTH_SIGNED_SEL_EN
   localparam int QW = WIDTH + 1;
`else
   localparam int QW = WIDTH;
`endif
   localparam int CW = clog2(QW) + 1;

   state_t          state_q, state_d;
   booth_op_t       op;
   logic [AW-1:0]   a_q, m_q, sum, a_step;
   logic [QW-1:0]   q_q;
   logic            qm1_q;
   logic [CW-1:0]   cnt_q, last_cnt;
   logic            sgn_q;
   logic            alive_q;
   logic            accept, last_step;
   logic            in_rdy, out_vld;

   // Held low through reset, high from the first clock afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive_q <= 1'b0;
      else        alive_q <= 1'b1;
   end

   // Booth recoding of the current multiplier bit pair
   always_comb begin
      op = NOP;
      unique case ({q_q[0], qm1_q})
         2'b01:   op = ADD;
         2'b10:   op = SUB;
         default: op = NOP;
      endcase
   end

   addsub_param #(.W(AW)) u_addsub (
      .cin (op == SUB),
      .a   (a_q),
      .b   (m_q),
      .sum (sum)
   );

   assign a_step = (op == NOP) ? a_q : sum;

   // Unsigned operands are zero-extended by one bit and need one more step
   always_comb begin
      last_cnt = CW'(WIDTH - 1);
`ifdef BOOTH_SIGNED_SEL_EN
      if (!sgn_q) last_cnt = CW'(WIDTH);
`endif
   end

   assign last_step = (cnt_q == last_cnt);
   assign accept    = (state_q == IDLE) && alive_q && bus.in_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_rdy = alive_q;
            if (bus.in_valid && alive_q) state_d = CALC;
         end
         CALC: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_vld = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand load and the add/shift datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         m_q   <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
         cnt_q <= '0;
         sgn_q <= 1'b0;
      end else if (accept) begin
         a_q   <= '0;
         qm1_q <= 1'b0;
         cnt_q <= '0;
`ifdef BOOTH_SIGNED_SEL_EN
         sgn_q <= bus.is_signed;
         m_q   <= {bus.is_signed & bus.multcand[WIDTH-1], bus.multcand};
         q_q   <= {bus.is_signed & bus.multplr[WIDTH-1], bus.multplr};
`else
         sgn_q <= 1'b1;
         m_q   <= {bus.multcand[WIDTH-1], bus.multcand};
         q_q   <= bus.multplr;
`endif
      end else if (state_q == CALC) begin
         a_q   <= {a_step[AW-1], a_step[AW-1:1]};
         q_q   <= {a_step[0], q_q[QW-1:1]};
         qm1_q <= q_q[0];
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;

   // Signed runs stop one step short of the widened Q register, so the
   // product sits one bit higher than for unsigned runs.
`ifdef BOOTH_SIGNED_SEL_EN
   assign bus.product = sgn_q ? {a_q[WIDTH-1:0], q_q[QW-1:1]}
                              : {a_q[WIDTH-2:0], q_q};
`else
   assign bus.product = {a_q[WIDTH-1:0], q_q};
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
// Honours BOOTH_SIGNED_SEL_EN when the design is built with it.
module tb_booth_mult_seq;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDTH(W)) bus ();

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer multiply of the interpreted operands
   function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                            input logic sgn);
      longint a, b, p;
      a = sgn ? longint'($signed(m)) : longint'({1'b0, m});
      b = sgn ? longint'($signed(q)) : longint'({1'b0, q});
      p = a * b;
      return p[2*W-1:0];
   endfunction

   function automatic int exp_lat(input logic sgn);
`ifdef BOOTH_SIGNED_SEL_EN
      return sgn ? W + 1 : W + 2;
`else
      return sgn ? W + 1 : W + 1;
`endif
   endfunction

   // Every cycle the product is offered it must equal the oldest outstanding result
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'd1, 64'd0);
         end else begin
            check("product_stream", 64'(bus.product), 64'(exp_q[0]));
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Called #1 after a rising edge; returns at the same phase.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sgn,
                         input int bp, input bit junk,
                         output logic [2*W-1:0] got, output int lat);
      int k;
      k = 0;
      got = 'x;
      lat = 0;
      while (!bus.in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", 64'd0, 64'd1);
         return;
      end
      bus.out_ready = (bp == 0);
      bus.in_valid  = 1'b1;
      bus.multcand  = m;
      bus.multplr   = q;
`ifdef BOOTH_SIGNED_SEL_EN
      bus.is_signed = sgn;
`endif
      exp_q.push_back(model(m, q, sgn));
      @(posedge clk); #1;
      if (junk) begin
         bus.multcand = W'($urandom);
         bus.multplr  = W'($urandom);
`ifdef BOOTH_SIGNED_SEL_EN
         bus.is_signed = 1'($urandom);
`endif
      end else begin
         bus.in_valid = 1'b0;
      end
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      if (!bus.out_valid) begin
         check("out_valid_timeout", 64'd0, 64'd1);
         return;
      end
      got = bus.product;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_product_held", 64'(bus.product), 64'(got));
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic [2*W-1:0] got;
      int lat;
      int hits;
      logic [W-1:0] m, q;
      logic sgn;

      bus.in_valid  = 1'b0;
      bus.multcand  = '0;
      bus.multplr   = '0;
      bus.out_ready = 1'b1;
`ifdef BOOTH_SIGNED_SEL_EN
      bus.is_signed = 1'b1;
`endif

      // Reset values
      @(posedge clk); @(posedge clk); #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_product", 64'(bus.product), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);

      // Hand-computed corner cases
      run_op(8'd7, 8'd3, 1'b1, 0, 1'b0, got, lat);
      check("basic_7x3", 64'(got), 64'h0015);
      check("basic_latency", 64'(lat), 64'd9);
      check("model_7x3", 64'(model(8'd7, 8'd3, 1'b1)), 64'h0015);
      run_op(8'h80, 8'h80, 1'b1, 0, 1'b0, got, lat);
      check("neg128_sq", 64'(got), 64'h4000);
      run_op(8'h80, 8'h7F, 1'b1, 1, 1'b0, got, lat);
      check("neg128_x127", 64'(got), 64'hC080);
      check("model_neg128_x127", 64'(model(8'h80, 8'h7F, 1'b1)), 64'hC080);
      run_op(8'h00, 8'h5A, 1'b1, 0, 1'b1, got, lat);
      check("zero_x5a", 64'(got), 64'h0000);
      run_op(8'hFD, 8'd5, 1'b1, 20, 1'b1, got, lat);
      check("backpressure_m3x5", 64'(got), 64'hFFF1);

      // Abort on the 4th CALC cycle
      bus.in_valid = 1'b1;
      bus.multcand = 8'd7;
      bus.multplr  = 8'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_product", 64'(bus.product), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      hits = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.out_valid) hits++;
      end
      check("abort_no_product", 64'(hits), 64'd0);
      run_op(8'd5, 8'hFA, 1'b1, 0, 1'b0, got, lat);
      check("after_abort_5xm6", 64'(got), 64'hFFE2);

`ifdef BOOTH_SIGNED_SEL_EN
      run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, got, lat);
      check("unsigned_255sq", 64'(got), 64'hFE01);
      check("unsigned_latency", 64'(lat), 64'd10);
      run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, got, lat);
      check("signed_ffsq", 64'(got), 64'h0001);
      check("signed_latency", 64'(lat), 64'd9);
`endif

      // Randomized operations
      for (int n = 0; n < 60; n++) begin
         m = W'($urandom);
         q = W'($urandom);
`ifdef BOOTH_SIGNED_SEL_EN
         sgn = 1'($urandom);
`else
         sgn = 1'b1;
`endif
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(m, q, sgn, int'($urandom_range(0, 3)), 1'($urandom), got, lat);
         check("rand_latency", 64'(lat), 64'(exp_lat(sgn)));
         check("rand_product", 64'(got), 64'(model(m, q, sgn)));
      end

      repeat (3) begin @(posedge clk); #1; end
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
